// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, grant encoding and bus widths.
package sdram_arb_pkg;

  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD       = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker; an urgent writer always wins regardless of history.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  logic wr_urgent,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant       = GNT_WR;
    grant_valid = wr_req || rd_req;
    if (wr_req && wr_urgent) begin
      grant = GNT_WR;
    end else if (wr_req && rd_req) begin
      // Tie: hand the port to whichever side did not have it last.
      grant = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Burst arbiter sharing one SDRAM controller port between the capture writer and readout reader.
// Define SDRAM_ARB_STATS_EN to add saturating burst/stall statistics outputs.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 256,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              wr_urgent,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic [BE_W-1:0]   az_be_n,
  output logic              az_cs,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic              busy,
  output logic              err
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wr_bursts,
  output logic [15:0]       stat_rd_bursts,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  state_t              state_reg, state_next;
  grant_t              last_grant_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [PEND_W-1:0]   pending_reg, pending_next;
  logic                wr_done_reg, rd_done_reg, rd_valid_reg, err_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  logic                rr_grant, rr_valid;
  logic                wr_accept, rd_accept;
  logic                cnt_last, rd_allowed, za_valid_ok;
  logic [ADDR_W-1:0]   cmd_addr;

  sdram_arb_rr u_rr (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_urgent   (wr_urgent),
    .last_grant  (last_grant_reg),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign cmd_addr    = base_reg + ADDR_W'(cnt_reg);
  assign cnt_last    = (cnt_reg == CNT_W'(BURST_LEN - 1));
  assign rd_allowed  = (pending_reg < PEND_W'(MAX_PENDING));
  // Returns with nothing outstanding are dropped and flagged instead of forwarded.
  assign za_valid_ok = za_valid && (pending_reg != '0);

  always_comb begin
    pending_next = pending_reg;
    case ({rd_accept, za_valid_ok})
      2'b10:   pending_next = pending_reg + PEND_W'(1);
      2'b01:   pending_next = pending_reg - PEND_W'(1);
      default: pending_next = pending_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    az_cs      = 1'b0;
    az_rd_n    = 1'b1;
    az_wr_n    = 1'b1;
    az_addr    = '0;
    az_data    = '0;
    wr_pop     = 1'b0;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rr_valid) state_next = (rr_grant == GNT_WR) ? WR : RD;
      end
      WR: begin
        az_cs   = 1'b1;
        az_wr_n = 1'b0;
        az_addr = cmd_addr;
        az_data = wr_data;
        if (!za_waitrequest) begin
          wr_pop    = 1'b1;
          wr_accept = 1'b1;
          if (cnt_last) state_next = IDLE;
        end
      end
      RD: begin
        az_addr = cmd_addr;
        if (rd_allowed) begin
          az_cs   = 1'b1;
          az_rd_n = 1'b0;
          if (!za_waitrequest) begin
            rd_accept = 1'b1;
            if (cnt_last) state_next = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (pending_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_RD;
      base_reg       <= '0;
      cnt_reg        <= '0;
      pending_reg    <= '0;
      wr_done_reg    <= 1'b0;
      rd_done_reg    <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (state_reg == IDLE && rr_valid) begin
        base_reg       <= (rr_grant == GNT_WR) ? wr_addr : rd_addr;
        cnt_reg        <= '0;
        last_grant_reg <= grant_t'(rr_grant);
      end else if (wr_accept || rd_accept) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      wr_done_reg  <= wr_accept && cnt_last;
      rd_done_reg  <= (state_reg == RD_DRAIN) && (pending_next == '0);
      rd_valid_reg <= za_valid_ok;
      if (za_valid_ok) rd_data_reg <= za_data;
      if (za_valid && pending_reg == '0) err_reg <= 1'b1;
    end
  end

  assign az_be_n  = '0;
  assign wr_done  = wr_done_reg;
  assign rd_done  = rd_done_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] stat_wr_reg, stat_rd_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_wr_reg    <= '0;
      stat_rd_reg    <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (wr_done_reg && stat_wr_reg != '1) stat_wr_reg <= stat_wr_reg + 16'd1;
      if (rd_done_reg && stat_rd_reg != '1) stat_rd_reg <= stat_rd_reg + 16'd1;
      if (az_cs && za_waitrequest && stat_stall_reg != '1)
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_wr_bursts    = stat_wr_reg;
  assign stat_rd_bursts    = stat_rd_reg;
  assign stat_stall_cycles = stat_stall_reg;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with BURST_LEN=4, MAX_PENDING=2 and a fixed-latency controller model.
module tb_sdram_arbiter;

  localparam int ADDR_W      = 21;
  localparam int DATA_W      = 16;
  localparam int BURST_LEN   = 4;
  localparam int MAX_PENDING = 2;
  localparam int LAT         = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_req, wr_urgent, wr_pop, wr_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr, az_addr;
  logic [DATA_W-1:0] wr_data, rd_data, az_data, za_data;
  logic              rd_req, rd_valid, rd_done;
  logic [1:0]        az_be_n;
  logic              az_cs, az_rd_n, az_wr_n;
  logic              za_valid, za_waitrequest, busy, err;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]       stat_wr_bursts, stat_rd_bursts;
  logic [31:0]       stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_urgent(wr_urgent), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_pop(wr_pop), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .az_addr(az_addr), .az_data(az_data), .az_be_n(az_be_n), .az_cs(az_cs),
    .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest),
    .busy(busy), .err(err)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Controller model: every accepted read returns (addr ^ 0x5A5A) LAT cycles later.
  logic [ADDR_W-1:0] q_addr[$];
  int                q_due[$];
  int                cyc_n = 0;
  logic              inject_valid = 1'b0;

  initial begin
    za_valid = 1'b0;
    za_data  = '0;
    forever begin
      @(posedge clk);
      cyc_n++;
      if (reset) begin
        q_addr.delete();
        q_due.delete();
      end else if (az_cs && !az_rd_n && !za_waitrequest) begin
        q_addr.push_back(az_addr);
        q_due.push_back(cyc_n + LAT);
      end
      #1;
      if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
        za_valid = 1'b1;
        za_data  = q_addr[0][15:0] ^ 16'h5A5A;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        za_valid = inject_valid;
        za_data  = 16'hDEAD;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read burst at base 0x200, cycles C0..C15 after the grant edge.
  bit exp_rdn [0:15] = '{0,0,1,1,1,1,1,0,0,1,1,1,1,1,1,1};
  int exp_off [0:15] = '{0,1,2,2,2,2,2,2,3,0,0,0,0,0,0,0};
  bit exp_rv  [0:15] = '{0,0,0,0,0,0,0,1,1,0,0,0,0,0,1,1};
  bit exp_rd  [0:15] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};
  logic [ADDR_W-1:0] exp_wrap [0:3] = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};

  initial begin
    int    acc;
    int    nv;
    int    n_done;
    string seq;

    reset = 1'b1;
    wr_req = 1'b0; wr_urgent = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; za_waitrequest = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_n", 32'(az_rd_n), 1);
    chk("rst_wr_n", 32'(az_wr_n), 1);
    chk("rst_cs", 32'(az_cs), 0);
    chk("rst_addr", 32'(az_addr), 0);
    chk("rst_data", 32'(az_data), 0);
    chk("rst_be_n", 32'(az_be_n), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_err", 32'(err), 0);
    $display("reset: checked idle outputs");

    // Single write burst at 0x10
    wr_req = 1'b1; wr_addr = 21'h10;
    #1;
    chk("w1_idle_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wr_data = 16'(32'hA000 + i);
      #1;
      chk("w1_addr", 32'(az_addr), 32'h10 + i);
      chk("w1_wr_n", 32'(az_wr_n), 0);
      chk("w1_data", 32'(az_data), 32'hA000 + i);
      chk("w1_pop", 32'(wr_pop), 1);
      chk("w1_done_early", 32'(wr_done), 0);
    end
    next_cycle(); #1;
    chk("w1_done", 32'(wr_done), 1);
    chk("w1_end_busy", 32'(busy), 0);
    chk("w1_end_wr_n", 32'(az_wr_n), 1);
    chk("w1_end_pop", 32'(wr_pop), 0);
    wr_req = 1'b0;
    next_cycle(); #1;
    chk("w1_done_once", 32'(wr_done), 0);
    $display("write 0x10: burst of 4 complete");

    // Write with waitrequest toggling: stalled cycles hold address/data
    wr_req = 1'b1; wr_addr = 21'h40;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      za_waitrequest = (i % 2 == 0);
      wr_data = 16'(32'hB000 + acc);
      #1;
      chk("ws_addr", 32'(az_addr), 32'h40 + acc);
      chk("ws_data", 32'(az_data), 32'hB000 + acc);
      chk("ws_wr_n", 32'(az_wr_n), 0);
      chk("ws_pop", 32'(wr_pop), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) acc++;
    end
    next_cycle();
    za_waitrequest = 1'b0;
    #1;
    chk("ws_done", 32'(wr_done), 1);
    wr_req = 1'b0;
    next_cycle();
    $display("write 0x40 with stalls: complete");

    // Address wrap at top of the space
    wr_req = 1'b1; wr_addr = 21'h1FFFFE;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      chk("wrap_addr", 32'(az_addr), 32'(exp_wrap[i]));
    end
    next_cycle(); #1;
    chk("wrap_done", 32'(wr_done), 1);
    chk("wrap_err", 32'(err), 0);
    wr_req = 1'b0;
    next_cycle();
    $display("write 0x1FFFFE: wrapped to 0x000001");

    // Read burst with MAX_PENDING=2 and LAT-cycle controller returns
    rd_req = 1'b1; rd_addr = 21'h200;
    nv = 0;
    #1;
    for (int j = 0; j < 16; j++) begin
      next_cycle(); #1;
      chk("rd_rd_n", 32'(az_rd_n), 32'(exp_rdn[j]));
      if (!exp_rdn[j]) chk("rd_addr", 32'(az_addr), 32'h200 + exp_off[j]);
      chk("rd_valid", 32'(rd_valid), 32'(exp_rv[j]));
      if (exp_rv[j]) begin
        chk("rd_data", 32'(rd_data), 32'((16'h0200 + 16'(nv)) ^ 16'h5A5A));
        nv++;
      end
      chk("rd_done", 32'(rd_done), 32'(exp_rd[j]));
      chk("rd_busy", 32'(busy), (j == 15) ? 0 : 1);
      if (j == 15) rd_req = 1'b0;
    end
    next_cycle(); #1;
    chk("rd_done_once", 32'(rd_done), 0);
    chk("rd_valid_end", 32'(rd_valid), 0);
    $display("read 0x200: 4 words returned");

    // Both requesting: alternation, then urgent override
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 21'h300; rd_addr = 21'h400;
    n_done = 0;
    seq = "";
    for (int c = 0; c < 600 && n_done < 7; c++) begin
      next_cycle(); #1;
      if (n_done == 3 && busy) wr_urgent = 1'b1;
      if (wr_done || rd_done) begin
        seq = {seq, wr_done ? "W" : "R"};
        n_done++;
        if (n_done == 6) wr_urgent = 1'b0;
        if (n_done == 7) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end else begin
          next_cycle(); #1;
          chk("alt_gap_busy", 32'(busy), 1);
        end
      end
    end
    chk("alt_count", 32'(n_done), 7);
    n_cmp++;
    assert (seq == "WRWRWWR") else begin
      n_err++;
      $error("FAIL alt_order: observed %s expected WRWRWWR", seq);
    end
    next_cycle(); #1;
    chk("alt_idle", 32'(busy), 0);
    chk("alt_err", 32'(err), 0);
    $display("alternation: burst order %s", seq);

    // Reset in the middle of a read with two reads outstanding
    rd_req = 1'b1; rd_addr = 21'h500;
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    chk("mr_stall_rd_n", 32'(az_rd_n), 1);
    chk("mr_busy", 32'(busy), 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; rd_req = 1'b0;
    #1;
    chk("mr_busy_after", 32'(busy), 0);
    chk("mr_rd_n_after", 32'(az_rd_n), 1);
    chk("mr_cs_after", 32'(az_cs), 0);
    for (int k = 0; k < 10; k++) begin
      next_cycle(); #1;
      chk("mr_no_done", 32'(rd_done), 0);
      chk("mr_no_valid", 32'(rd_valid), 0);
    end
    chk("mr_err_clear", 32'(err), 0);
    inject_valid = 1'b1;
    next_cycle(); #1;
    inject_valid = 1'b0;
    chk("sp_err_pre", 32'(err), 0);
    next_cycle(); #1;
    chk("sp_err_set", 32'(err), 1);
    chk("sp_no_valid", 32'(rd_valid), 0);
    next_cycle(); #1;
    chk("sp_err_sticky", 32'(err), 1);
    $display("reset mid-read: aborted, spurious return flagged");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
